// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-wait timeout fault and retire counter.
// Optional: define CU_HALT_EN to make the all-ones opcode enter a sticky HALT state.
module multicycle_control_unit #(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               alu_zero,
  output logic               imem_req,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               branch,
  output logic [FUNCT_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [OPCODE_W-1:0] OP_R  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LD = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ST = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BR = OPCODE_W'(3);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [TW-1:0]        wait_q, wait_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic [OPCODE_W-1:0]  opcode_s;
  logic [FUNCT_W-1:0]   funct_s;
  logic                 timeout_s;
  logic                 retire_s;
  logic                 ir_unused_s;

  assign opcode_s    = ir_q[INSTR_W-1 -: OPCODE_W];
  assign funct_s     = ir_q[INSTR_W-OPCODE_W-1 -: FUNCT_W];
  assign ir_unused_s = ^ir_q[INSTR_W-OPCODE_W-FUNCT_W-1:0];
  // Last permitted wait cycle: a ready here still wins over the fault.
  assign timeout_s   = (wait_q == TW'(TIMEOUT - 1));
  assign state       = state_q;
  assign fault       = (state_q == S_FAULT);
  assign retired     = retired_q;

  // Next-state, IR capture, wait/retire bookkeeping and strobe decode.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retire_s   = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    alu_op     = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          ir_d     = instr_in;
          state_d  = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_R, OP_LD, OP_ST, OP_BR: state_d = S_EXEC;
          default: begin
`ifdef CU_HALT_EN
            if (&opcode_s) begin
              state_d = S_HALT;
            end else begin
              state_d  = S_FETCH;
              retire_s = 1'b1;
            end
`else
            state_d  = S_FETCH;
            retire_s = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC: begin
        case (opcode_s)
          OP_R: begin
            alu_op  = funct_s;
            state_d = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BR: begin
            branch   = 1'b1;
            alu_op   = funct_s;
            pc_write = alu_zero;
            pc_src   = alu_zero;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (opcode_s == OP_LD);
        mem_write = (opcode_s == OP_ST);
        if (dmem_ready) begin
          retire_s = (opcode_s != OP_LD);
          state_d  = (opcode_s == OP_LD) ? S_WB : S_FETCH;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_s == OP_LD);
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      wait_d = wait_q + TW'(1);
    end else begin
      wait_d = wait_q;
    end
    retired_d = retired_q + CNT_W'(retire_s);
  end

  // State, IR, wait counter and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle trace expected from an instruction-level model of the control unit.
module tb_multicycle_control_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
  logic        imem_req, ir_load, pc_write, pc_src, reg_write, mem_read, mem_write;
  logic        mem_to_reg, alu_src, branch, fault;
  logic [2:0]  alu_op, state;
  logic [3:0]  retired;

  int total = 0;
  int bad = 0;
  int model_ret = 0;
  logic [18:0] stim_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  logic [20:0] o_v, e_v;

  multicycle_control_unit #(.INSTR_W(16), .OPCODE_W(4), .FUNCT_W(3), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch),
    .alu_op(alu_op), .state(state), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] pack();
    return {imem_req, ir_load, pc_write, pc_src, reg_write, mem_read, mem_write,
            mem_to_reg, alu_src, branch, alu_op, state, fault, retired};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  // strobes: imem_req ir_load pc_write pc_src reg_write mem_read mem_write mem_to_reg alu_src branch
  function automatic logic [20:0] mk(logic [9:0] s, logic [2:0] aop, logic [2:0] st, logic flt);
    return {s, aop, st, flt, model_ret[3:0]};
  endfunction

  function automatic void push(logic ir, logic dr, logic az, logic [15:0] ins, logic [20:0] e);
    stim_q.push_back({ir, dr, az, ins});
    exp_q.push_back(e);
  endfunction

  function automatic void add_stuck(int n, logic [2:0] st, logic flt);
    for (int k = 0; k < n; k++) push(rb(), rb(), rb(), rw(), mk(10'b0, 3'd0, st, flt));
  endfunction

  // Instruction-level model: di/dd = wait cycles before imem/dmem ready (>=TO means never ready).
  function automatic void build(logic [15:0] ins, int di, int dd, logic az, int stuck);
    logic [3:0] op;
    logic [2:0] fn;
    logic [9:0] ms;
    op = ins[15:12];
    fn = ins[11:9];
    for (int k = 0; k < di && k < TO; k++) push(1'b0, rb(), rb(), rw(), mk(10'b10_0000_0000, 3'd0, 3'd1, 1'b0));
    if (di >= TO) begin add_stuck(stuck, 3'd6, 1'b1); return; end
    push(1'b1, rb(), rb(), ins, mk(10'b11_1000_0000, 3'd0, 3'd1, 1'b0));
    push(rb(), rb(), rb(), rw(), mk(10'b0, 3'd0, 3'd2, 1'b0));
`ifdef CU_HALT_EN
    if (op == 4'hF) begin add_stuck(stuck, 3'd7, 1'b0); return; end
`endif
    if (op > 4'd3) begin model_ret++; return; end
    if (op == 4'd3) begin
      push(rb(), rb(), az, rw(), mk({2'b00, az, az, 5'b00000, 1'b1}, fn, 3'd3, 1'b0));
      model_ret++;
      return;
    end
    if (op == 4'd0) begin
      push(rb(), rb(), rb(), rw(), mk(10'b0, fn, 3'd3, 1'b0));
      push(rb(), rb(), rb(), rw(), mk(10'b00_0010_0000, 3'd0, 3'd5, 1'b0));
      model_ret++;
      return;
    end
    push(rb(), rb(), rb(), rw(), mk(10'b00_0000_0010, 3'd0, 3'd3, 1'b0));
    ms = (op == 4'd1) ? 10'b00_0001_0000 : 10'b00_0000_1000;
    for (int k = 0; k < dd && k < TO; k++) push(rb(), 1'b0, rb(), rw(), mk(ms, 3'd0, 3'd4, 1'b0));
    if (dd >= TO) begin add_stuck(stuck, 3'd6, 1'b1); return; end
    push(rb(), 1'b1, rb(), rw(), mk(ms, 3'd0, 3'd4, 1'b0));
    if (op == 4'd2) begin model_ret++; return; end
    push(rb(), rb(), rb(), rw(), mk(10'b00_0010_0100, 3'd0, 3'd5, 1'b0));
    model_ret++;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {imem_ready, dmem_ready, alu_zero, instr_in} = 19'd0;
    model_ret = 0;
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic run(input int n);
    logic [18:0] s;
    for (int k = 0; k < n && stim_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
      s = stim_q.pop_front();
      {imem_ready, dmem_ready, alu_zero, instr_in} = s;
      #1;
      obs_q.push_back(pack());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (pack() !== 21'd0) begin bad++; $display("FAIL reset_asserted: got %h expected 0", pack()); end
    do_reset();
    total++;
    if (pack() !== 21'd0) begin bad++; $display("FAIL reset_idle: got %h expected 0", pack()); end
  endtask

  task automatic test_rtype();
    do_reset();
    build(16'h0600, 0, 0, 1'b0, 0);
    build(16'h0600, 1, 0, 1'b0, 0);
    run(1000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL rtype: got %h expected %h", o_v, e_v); end
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    build(16'h1000, 0, 3, 1'b0, 0);
    build(16'h3200, 0, 0, 1'b1, 0);
    build(16'h3200, 2, 0, 1'b0, 0);
    build(16'h2000, 1, 2, 1'b0, 0);
    build(16'h0600, 0, 0, 1'b0, 0);
    run(1000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL load_branch: got %h expected %h", o_v, e_v); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    build(16'h0600, TO - 1, 0, 1'b0, 0);
    build(16'h1000, 0, TO - 1, 1'b0, 0);
    build(16'h2000, 0, TO, 1'b0, 6);
    run(1000);
    do_reset();
    build(16'h0600, TO, 0, 1'b0, 6);
    run(1000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL timeout: got %h expected %h", o_v, e_v); end
    end
  endtask

  task automatic test_opcode_f();
    do_reset();
    build(16'hF000, 0, 0, 1'b0, 4);
`ifndef CU_HALT_EN
    build(16'h0600, 0, 0, 1'b0, 0);
`endif
    run(1000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL opcode_f: got %h expected %h", o_v, e_v); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    build(16'h0600, 0, 0, 1'b0, 0);
    build(16'h2000, 0, 10, 1'b0, 0);
    run(4 + 3 + 3);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL pre_reset: got %h expected %h", o_v, e_v); end
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mid_wr: got %b expected 0", mem_write); end
    total++;
    if (pack() !== 21'd0) begin bad++; $display("FAIL reset_mid: got %h expected 0", pack()); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) build({4'($urandom_range(4, 14)), 12'($urandom)}, 0, 0, 1'b0, 0);
    build(16'h0600, 0, 0, 1'b0, 0);
    build(16'h0600, 0, 0, 1'b0, 0);
    run(1000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL wrap: got %h expected %h", o_v, e_v); end
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] op;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      op = (r == 4) ? 4'($urandom_range(4, 14)) : ((r == 5) ? 4'd0 : 4'(r));
      build({op, 12'($urandom)},
            ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3), rb(), 0);
    end
    run(100000);
    while (obs_q.size() > 0) begin
      o_v = obs_q.pop_front(); e_v = exp_q.pop_front(); total++;
      if (o_v !== e_v) begin bad++; $display("FAIL random: got %h expected %h", o_v, e_v); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_branch();
    test_timeout();
    test_opcode_f();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
